// File: rtl/delay_pkg.sv
// Shared constants, FSM state encoding and width helper for the delay timer blocks.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package delay_pkg;

  localparam int US_PER_S = 1_000_000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Number of bits needed to hold the value v (never less than 1).
  function automatic int clogb2(input int unsigned v);
    int r;
    r = 1;
    for (int i = 0; i < 32; i++) begin
      if ((v >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/delay_timer_tick_prescaler.sv
// Mod-PRESC cycle counter that marks the last cycle of every base tick.
// Latency: wrap is combinational from the count register, asserted in the cycle whose edge wraps it.
// Backpressure: none; en freezes the count, clr forces it to zero and wins over en.
module tick_prescaler
  import delay_pkg::*;
#(
  parameter int PRESC = 4,
  parameter int PW    = clogb2(PRESC)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam logic [PW-1:0] LAST = PW'(PRESC - 1);

  logic [PW-1:0] cnt;

  assign wrap = en && !clr && (cnt == LAST);

  // Count enabled cycles modulo PRESC; a clear restarts the tick phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/delay_timer.sv
// Programmable one-shot / periodic delay timer counting base ticks of TICK_US microseconds.
// Latency: first tick PRESC edges after the start edge, expiry ticks*PRESC edges after it; outputs registered.
// Backpressure: none; enable low freezes all timing for that cycle, start/stop act regardless of enable.
module delay_timer
  import delay_pkg::*;
#(
  parameter  int CLK_HZ    = 50_000_000,
  parameter  int TICK_US   = 1000,
  parameter  int MAX_TICKS = 1000,
  localparam int TW        = clogb2(MAX_TICKS)
) (
  input  logic          CLOCK_50,
  input  logic          aclr,
  input  logic          enable,
  input  logic          start,
  input  logic          stop,
  input  logic          periodic,
  input  logic [TW-1:0] ticks,
  output logic          tick,
  output logic          done,
  output logic          Q,
  output logic          busy,
  output logic [TW-1:0] remaining
);

  localparam int PRESC = CLK_HZ / US_PER_S * TICK_US;
  localparam int PW    = clogb2(PRESC);
  localparam logic [TW-1:0] MAX_T = TW'(MAX_TICKS);

  if (CLK_HZ % US_PER_S != 0) begin : g_bad_clk
    $error("delay_timer: CLK_HZ must be a whole number of MHz");
  end

  state_t        state, state_n;
  logic [TW-1:0] rem_n;
  logic [TW-1:0] lat, lat_n;
  logic          per, per_n;
  logic          tick_n, done_n, q_n;
  logic [TW-1:0] ticks_clamped;
  logic          presc_clr, presc_en, presc_wrap;

  assign ticks_clamped = (ticks > MAX_T) ? MAX_T : ticks;

  // The prescaler only advances in a plain counting cycle; any start/stop or idle time re-phases it.
  assign presc_en  = (state == ST_RUN) && enable && !start && !stop;
  assign presc_clr = start || stop || (state == ST_IDLE);

  assign busy = (state == ST_RUN);

  tick_prescaler #(
    .PRESC (PRESC),
    .PW    (PW)
  ) u_presc (
    .clk  (CLOCK_50),
    .rst  (aclr),
    .clr  (presc_clr),
    .en   (presc_en),
    .wrap (presc_wrap)
  );

  // Next state: stop beats start beats expiry beats plain tick counting.
  always_comb begin
    state_n = state;
    rem_n   = remaining;
    lat_n   = lat;
    per_n   = per;
    tick_n  = 1'b0;
    done_n  = 1'b0;
    q_n     = Q;
    if (stop) begin
      state_n = ST_IDLE;
      rem_n   = '0;
    end else if (start) begin
      if (ticks != '0) begin
        state_n = ST_RUN;
        rem_n   = ticks_clamped;
        lat_n   = ticks_clamped;
        per_n   = periodic;
      end else begin
        // A zero-length start is ignored when idle and aborts a running interval.
        state_n = ST_IDLE;
        rem_n   = '0;
      end
    end else if (presc_wrap) begin
      tick_n = 1'b1;
      if (remaining == TW'(1)) begin
        done_n = 1'b1;
        q_n    = !Q;
        if (per) begin
          rem_n = lat;
        end else begin
          rem_n   = '0;
          state_n = ST_IDLE;
        end
      end else begin
        rem_n = remaining - 1'b1;
      end
    end
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge CLOCK_50 or posedge aclr) begin
    if (aclr) begin
      state     <= ST_IDLE;
      remaining <= '0;
      lat       <= '0;
      per       <= 1'b0;
      tick      <= 1'b0;
      done      <= 1'b0;
      Q         <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= rem_n;
      lat       <= lat_n;
      per       <= per_n;
      tick      <= tick_n;
      done      <= done_n;
      Q         <= q_n;
    end
  end

endmodule

// File: tb/tb_delay_timer.sv
module tb_delay_timer;
  import delay_pkg::*;

  localparam int CLK_HZ    = 4_000_000;
  localparam int TICK_US   = 1;
  localparam int MAX_TICKS = 15;
  localparam int PRESC     = CLK_HZ / 1_000_000 * TICK_US;
  localparam int TW        = clogb2(MAX_TICKS);

  logic          clk = 1'b0;
  logic          aclr;
  logic          enable, start, stop, periodic;
  logic [TW-1:0] ticks;
  logic          tick, done, q, busy;
  logic [TW-1:0] remaining;

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;
  int e0    = 0;
  int done_cnt = 0;
  int d0    = 0;

  // Behavioural model: timing expressed as enabled cycles since the last (re)start.
  bit m_run = 0, m_per = 0, m_q = 0, m_tick = 0, m_done = 0;
  int m_lat = 0, m_en = 0, m_rem = 0;

  delay_timer #(
    .CLK_HZ    (CLK_HZ),
    .TICK_US   (TICK_US),
    .MAX_TICKS (MAX_TICKS)
  ) dut (
    .CLOCK_50  (clk),
    .aclr      (aclr),
    .enable    (enable),
    .start     (start),
    .stop      (stop),
    .periodic  (periodic),
    .ticks     (ticks),
    .tick      (tick),
    .done      (done),
    .Q         (q),
    .busy      (busy),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecnt++;

  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_cnt++;
  end

  always @(posedge clk or posedge aclr) begin
    int k;
    if (aclr) begin
      m_run = 0; m_per = 0; m_q = 0; m_tick = 0; m_done = 0;
      m_lat = 0; m_en = 0; m_rem = 0;
    end else begin
      m_tick = 0;
      m_done = 0;
      if (stop) begin
        m_run = 0;
        m_rem = 0;
      end else if (start) begin
        if (ticks != 0) begin
          m_run = 1;
          m_lat = (int'(ticks) > MAX_TICKS) ? MAX_TICKS : int'(ticks);
          m_per = periodic;
          m_en  = 0;
          m_rem = m_lat;
        end else begin
          m_run = 0;
          m_rem = 0;
        end
      end else if (m_run && enable) begin
        m_en++;
        if (m_en % PRESC == 0) begin
          k = m_en / PRESC;
          m_tick = 1;
          if (k % m_lat == 0) begin
            m_done = 1;
            m_q = !m_q;
            if (!m_per) m_run = 0;
          end
          m_rem = m_run ? m_lat - (k % m_lat) : 0;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [TW+3:0] exp_v, act_v;
    exp_v = {m_tick, m_done, m_q, m_run, TW'(m_rem)};
    act_v = {tick, done, q, busy, remaining};
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL model_cycle edge=%0d act=%b exp=%b (tick,done,Q,busy,remaining)", ecnt, act_v, exp_v);
    end
  end

  task automatic expect_o(input string name, input bit t, input bit d, input bit qq, input bit b, input int r);
    logic [TW+3:0] a, e;
    a = {tick, done, q, busy, remaining};
    e = {t, d, qq, b, TW'(r)};
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%b exp=%b (tick,done,Q,busy,remaining)", name, a, e);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic do_start(input int t, input bit p);
    @(negedge clk);
    ticks = TW'(t);
    periodic = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = ecnt;
  endtask

  task automatic at(input int n);
    while (ecnt < e0 + n) @(negedge clk);
  endtask

  task automatic rst_dut();
    @(negedge clk);
    #2;
    aclr = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    aclr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time=%0t limit=100000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    aclr = 1'b1;
    enable = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    periodic = 1'b0;
    ticks = '0;
    repeat (2) @(negedge clk);
    expect_o("reset", 0, 0, 0, 0, 0);
    aclr = 1'b0;

    // One-shot, 3 ticks
    do_start(3, 0);
    expect_o("os_e0", 0, 0, 0, 1, 3);
    at(4);  expect_o("os_e4", 1, 0, 0, 1, 2);
    at(5);  expect_o("os_e5", 0, 0, 0, 1, 2);
    at(8);  expect_o("os_e8", 1, 0, 0, 1, 1);
    at(11); expect_o("os_e11", 0, 0, 0, 1, 1);
    at(12); expect_o("os_e12", 1, 1, 1, 0, 0);
    at(13); expect_o("os_e13", 0, 0, 1, 0, 0);

    // Periodic, 2 ticks, stop at E25
    rst_dut();
    d0 = done_cnt;
    do_start(2, 1);
    at(8);  expect_o("per_e8", 1, 1, 1, 1, 2);
    at(12); expect_o("per_e12", 1, 0, 1, 1, 1);
    at(16); expect_o("per_e16", 1, 1, 0, 1, 2);
    at(24); expect_o("per_e24", 1, 1, 1, 1, 2);
    stop = 1'b1;
    at(25); stop = 1'b0;
    expect_o("per_stop", 0, 0, 1, 0, 0);
    at(40); chk_int("per_done_count", done_cnt - d0, 3);

    // One-shot with enable low on edges E2..E6
    rst_dut();
    do_start(3, 0);
    at(1);  enable = 1'b0;
    at(6);  expect_o("en_frozen", 0, 0, 0, 1, 3);
    enable = 1'b1;
    at(9);  expect_o("en_e9", 1, 0, 0, 1, 2);
    at(16); expect_o("en_e16", 0, 0, 0, 1, 1);
    at(17); expect_o("en_e17", 1, 1, 1, 0, 0);

    // Stop at E6 with Q high: Q held, no done
    d0 = done_cnt;
    do_start(3, 0);
    at(5);  stop = 1'b1;
    at(6);  stop = 1'b0;
    expect_o("stop_e6", 0, 0, 1, 0, 0);
    at(20); chk_int("stop_no_done", done_cnt - d0, 0);

    // Zero-length start when idle, start+stop together, zero-length start while running
    do_start(0, 0);
    expect_o("start_zero_idle", 0, 0, 1, 0, 0);
    @(negedge clk);
    ticks = TW'(2); periodic = 1'b1; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    expect_o("start_and_stop", 0, 0, 1, 0, 0);
    do_start(2, 1);
    at(3);
    do_start(0, 0);
    expect_o("start_zero_run", 0, 0, 1, 0, 0);

    // Largest delay
    do_start(MAX_TICKS, 0);
    at(4);  expect_o("max_e4", 1, 0, 1, 1, 14);
    at(59); expect_o("max_e59", 0, 0, 1, 1, 1);
    at(60); expect_o("max_e60", 1, 1, 0, 0, 0);

    // Restart coinciding with expiry
    rst_dut();
    d0 = done_cnt;
    do_start(3, 0);
    at(11); ticks = TW'(1); periodic = 1'b0; start = 1'b1;
    at(12); start = 1'b0;
    expect_o("restart_e12", 0, 0, 0, 1, 1);
    at(15); expect_o("restart_e15", 0, 0, 0, 1, 1);
    at(16); expect_o("restart_e16", 1, 1, 1, 0, 0);
    chk_int("restart_done_count", done_cnt - d0, 1);

    // Asynchronous clear mid-run
    rst_dut();
    do_start(2, 1);
    at(10); expect_o("pre_aclr", 0, 0, 1, 1, 2);
    #1 aclr = 1'b1;
    #1 expect_o("aclr_async", 0, 0, 0, 0, 0);
    @(negedge clk);
    aclr = 1'b0;
    repeat (6) @(negedge clk);
    expect_o("after_aclr", 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
